// File: rtl/unary_ctrl_pkg.sv
// rtl/unary_ctrl_pkg.sv - shared state encoding and default widths for the unary array controller
package unary_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int DEF_ROWS   = 4;
  localparam int DEF_CWIDTH = 8;
  localparam int DEF_KWIDTH = 8;

endpackage

// File: rtl/unary_skew_line.sv
// rtl/unary_skew_line.sv - per-row delay line for {clr,en,last}; row r lags the base by r cycles
module unary_skew_line #(
  parameter int ROWS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic [2:0]      base,
  output logic [ROWS-1:0] clr_row,
  output logic [ROWS-1:0] en_row,
  output logic [ROWS-1:0] last_row
);

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [2:0] q;

    // Row 0 taps the already-registered base directly, so it adds no delay.
    if (r == 0) begin : g_head
      assign q = base;
    end else begin : g_tap
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q <= 3'b000;
        end else if (flush) begin
          q <= 3'b000;
        end else begin
          q <= g_row[r-1].q;
        end
      end
    end

    assign clr_row[r]  = q[2];
    assign en_row[r]   = q[1];
    assign last_row[r] = q[0];
  end

endmodule

// File: rtl/unary_array_ctrl.sv
// rtl/unary_array_ctrl.sv - tile sequencer: clear, run K vectors of len cycles, drain skew, signal done
module unary_array_ctrl
  import unary_ctrl_pkg::*;
#(
  parameter int ROWS   = DEF_ROWS,
  parameter int CWIDTH = DEF_CWIDTH,
  parameter int KWIDTH = DEF_KWIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CWIDTH-1:0] cfg_cycles,
  input  logic [KWIDTH-1:0] cfg_depth,
  input  logic              in_valid,
  output logic              busy,
  output logic              done,
  output logic [ROWS-1:0]   clr_row,
  output logic [ROWS-1:0]   en_row,
  output logic [ROWS-1:0]   last_row
);

  localparam int              DW         = $clog2(ROWS) + 1;
  localparam logic [DW-1:0]   DRAIN_LAST = DW'((ROWS > 1) ? ROWS - 2 : 0);
  localparam bit              HAS_DRAIN  = (ROWS > 1);

  state_t            state;
  logic [CWIDTH-1:0] len;
  logic [CWIDTH-1:0] cyc_cnt;
  logic [KWIDTH-1:0] depth;
  logic [KWIDTH-1:0] vec_cnt;
  logic [DW-1:0]     drain_cnt;
  logic              clr_base;
  logic              en_base;
  logic              last_base;
  logic              flush;
  logic              issue;
  logic              cyc_last;

  assign flush = abort && (state != IDLE);

  // Bases are registered, so the enable for the next cycle is scheduled one edge ahead.
  assign issue = in_valid &&
                 (((state == CLEAR) && (depth != '0)) ||
                  ((state == RUN) && (vec_cnt != depth)));
  assign cyc_last = (cyc_cnt == len - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      len       <= '0;
      depth     <= '0;
      cyc_cnt   <= '0;
      vec_cnt   <= '0;
      drain_cnt <= '0;
      clr_base  <= 1'b0;
      en_base   <= 1'b0;
      last_base <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      clr_base  <= 1'b0;
      en_base   <= 1'b0;
      last_base <= 1'b0;
      done      <= 1'b0;
      if (flush) begin
        state     <= IDLE;
        busy      <= 1'b0;
        cyc_cnt   <= '0;
        vec_cnt   <= '0;
        drain_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              len      <= (cfg_cycles == '0) ? CWIDTH'(1) : cfg_cycles;
              depth    <= cfg_depth;
              cyc_cnt  <= '0;
              vec_cnt  <= '0;
              clr_base <= 1'b1;
              busy     <= 1'b1;
              state    <= CLEAR;
            end
          end
          CLEAR, RUN: begin
            if ((state == CLEAR) ? (depth != '0) : (vec_cnt != depth)) begin
              state <= RUN;
            end else if (HAS_DRAIN) begin
              drain_cnt <= '0;
              state     <= DRAIN;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
          DRAIN: begin
            if (drain_cnt == DRAIN_LAST) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              drain_cnt <= drain_cnt + 1'b1;
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase

        if (issue) begin
          en_base   <= 1'b1;
          last_base <= cyc_last;
          if (cyc_last) begin
            cyc_cnt <= '0;
            vec_cnt <= vec_cnt + 1'b1;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
      end
    end
  end

  unary_skew_line #(
    .ROWS(ROWS)
  ) u_skew (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .base    ({clr_base, en_base, last_base}),
    .clr_row (clr_row),
    .en_row  (en_row),
    .last_row(last_row)
  );

endmodule

// File: tb/tb_unary_array_ctrl.sv
// tb/tb_unary_array_ctrl.sv - directed-vector bench for unary_array_ctrl with per-cycle output traces
module tb_unary_array_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] cfg_cycles;
  logic [7:0] cfg_depth;
  logic       in_valid;
  logic       busy;
  logic       done;
  logic [3:0] clr_row;
  logic [3:0] en_row;
  logic [3:0] last_row;

  int total = 0;
  int bad   = 0;

  logic [23:0] t_clr0, t_clr3, t_en0, t_en3, t_last0, t_last3, t_done, t_busy;

  unary_array_ctrl #(
    .ROWS(4),
    .CWIDTH(8),
    .KWIDTH(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .cfg_cycles(cfg_cycles),
    .cfg_depth (cfg_depth),
    .in_valid  (in_valid),
    .busy      (busy),
    .done      (done),
    .clr_row   (clr_row),
    .en_row    (en_row),
    .last_row  (last_row)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Cycle k starts just after posedge k; in_valid during cycle k shapes en in cycle k+1.
  task automatic run(input logic [7:0] cc, input logic [7:0] dd, input logic [23:0] stall,
                     input int ab_cyc, input int st2_cyc);
    for (int k = 0; k < 24; k++) begin
      start    = (k == 0) || (k == st2_cyc);
      abort    = (k == ab_cyc);
      in_valid = !stall[k];
      if (start) begin
        cfg_cycles = cc;
        cfg_depth  = dd;
      end else begin
        cfg_cycles = 8'($urandom);
        cfg_depth  = 8'($urandom);
      end
      @(negedge clk);
      t_clr0[k]  = clr_row[0];
      t_clr3[k]  = clr_row[3];
      t_en0[k]   = en_row[0];
      t_en3[k]   = en_row[3];
      t_last0[k] = last_row[0];
      t_last3[k] = last_row[3];
      t_done[k]  = done;
      t_busy[k]  = busy;
      @(posedge clk);
      #1;
    end
    start    = 1'b0;
    abort    = 1'b0;
    in_valid = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    cfg_cycles = 8'd0;
    cfg_depth  = 8'd0;
    in_valid   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_outs", 32'({clr_row, en_row, last_row}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // len=4, K=2, no stalls; a second start at t5 must be ignored
    run(8'd4, 8'd2, 24'h0, 99, 5);
    check("t1_clr0",  32'(t_clr0),  32'h000002);
    check("t1_clr3",  32'(t_clr3),  32'h000010);
    check("t1_en0",   32'(t_en0),   32'h0003FC);
    check("t1_en3",   32'(t_en3),   32'h001FE0);
    check("t1_last0", 32'(t_last0), 32'h000220);
    check("t1_last3", 32'(t_last3), 32'h001100);
    check("t1_done",  32'(t_done),  32'h002000);
    check("t1_busy",  32'(t_busy),  32'h003FFE);

    // in_valid low in cycles 3,4 gaps en_row[0] at t4,t5
    run(8'd4, 8'd2, 24'h000018, 99, 99);
    check("t2_en0",   32'(t_en0),   32'h000FCC);
    check("t2_en3",   32'(t_en3),   32'h007E60);
    check("t2_last0", 32'(t_last0), 32'h000880);
    check("t2_done",  32'(t_done),  32'h008000);
    check("t2_busy",  32'(t_busy),  32'h00FFFE);

    // cfg_cycles=0 behaves as len=1
    run(8'd0, 8'd3, 24'h0, 99, 99);
    check("t3_en0",   32'(t_en0),   32'h00001C);
    check("t3_last0", 32'(t_last0), 32'h00001C);
    check("t3_done",  32'(t_done),  32'h000100);
    check("t3_busy",  32'(t_busy),  32'h0001FE);

    // cfg_depth=0: clear then straight to drain
    run(8'd4, 8'd0, 24'h0, 99, 99);
    check("t4_clr0",  32'(t_clr0),  32'h000002);
    check("t4_en0",   32'(t_en0),   32'h000000);
    check("t4_done",  32'(t_done),  32'h000020);
    check("t4_busy",  32'(t_busy),  32'h00003E);

    // abort at t6, restart at t8
    run(8'd4, 8'd2, 24'h0, 6, 8);
    check("t5_clr0",  32'(t_clr0),  32'h000202);
    check("t5_clr3",  32'(t_clr3),  32'h001010);
    check("t5_en0",   32'(t_en0),   32'h03FC7C);
    check("t5_en3",   32'(t_en3),   32'h1FE060);
    check("t5_last0", 32'(t_last0), 32'h022020);
    check("t5_done",  32'(t_done),  32'h200000);
    check("t5_busy",  32'(t_busy),  32'h3FFE7E);

    // start together with abort while idle is dropped
    start = 1'b1;
    abort = 1'b1;
    cfg_cycles = 8'd4;
    cfg_depth  = 8'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("sa_busy", 32'(busy), 32'd0);
    check("sa_clr",  32'(clr_row), 32'd0);

    // asynchronous reset mid-run
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mr_pre_en", 32'(en_row), 32'h7);
    rst_n = 1'b0;
    #1;
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_outs", 32'({clr_row, en_row, last_row}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mr_after", 32'({busy, done, en_row}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
